// File: rtl/audio_codec_config.sv
// WM8731 power-up configuration sequencer: writes a fixed 10-entry register
// table over a bit-banged I2C bus, retries NACKed writes, and raises
// adc_enable once every entry has been acknowledged.
module audio_codec_config #(
    parameter int unsigned CLK_DIV     = 125,
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       start,
    input  logic       I2C_SDAT_IN,
    output logic       I2C_SCLK,
    output logic       I2C_SDAT_OE,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       adc_enable,
    output logic [3:0] reg_index
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_NEXT, S_DONE, S_ERR
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       q_q;
    logic [2:0]       bit_q;
    logic [1:0]       byte_q;
    logic [7:0]       retry_q;
    logic             nack_q;
    logic             fail_q;
    logic [3:0]       idx_q;
    logic             scl_q;
    logic             oe_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             tick;
    logic             launch;
    logic [7:0]       cur_byte;
    logic [7:0]       nxt_byte;

    // Register table, entry = {reg[6:0], data[8:0]} (R6 intentionally absent)
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {7'd15, 9'h000};
            4'd1:    return {7'd0,  9'h017};
            4'd2:    return {7'd1,  9'h017};
            4'd3:    return {7'd2,  9'h079};
            4'd4:    return {7'd3,  9'h079};
            4'd5:    return {7'd4,  9'h012};
            4'd6:    return {7'd5,  9'h000};
            4'd7:    return {7'd7,  9'h042};
            4'd8:    return {7'd8,  9'h000};
            4'd9:    return {7'd9,  9'h001};
            default: return '0;
        endcase
    endfunction

    // Byte sel of the write for table entry idx: address, {reg,d8}, d[7:0]
    function automatic logic [7:0] tx_byte(input logic [3:0] idx, input logic [1:0] sel);
        logic [15:0] e;
        e = table_entry(idx);
        case (sel)
            2'd0:    return {DEV_ADDR, 1'b0};
            2'd1:    return e[15:8];
            default: return e[7:0];
        endcase
    endfunction

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign launch = (state_q == S_IDLE) ||
                    (start && ((state_q == S_DONE) || (state_q == S_ERR)));

    // Current and following byte of the active write
    always_comb begin
        cur_byte = tx_byte(idx_q, byte_q);
        nxt_byte = tx_byte(idx_q, byte_q + 2'd1);
    end

    // Sequencer FSM; bus pins are updated on the same edge the quarter advances
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            retry_q <= '0;
            nack_q  <= 1'b0;
            fail_q  <= 1'b0;
            idx_q   <= '0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (launch) begin
            state_q <= S_START;
            div_q   <= '0;
            q_q     <= '0;
            byte_q  <= '0;
            retry_q <= '0;
            fail_q  <= 1'b0;
            idx_q   <= '0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            case (state_q)
                S_START: if (tick) begin
                    if (q_q == 2'd0) begin
                        q_q   <= 2'd1;
                        scl_q <= 1'b0;
                    end else begin
                        state_q <= S_BIT;
                        q_q     <= 2'd0;
                        bit_q   <= 3'd7;
                        oe_q    <= ~cur_byte[7];
                    end
                end
                S_BIT: if (tick) begin
                    q_q <= q_q + 2'd1;
                    case (q_q)
                        2'd0: scl_q <= 1'b1;
                        2'd2: scl_q <= 1'b0;
                        2'd3: begin
                            if (bit_q == 3'd0) begin
                                state_q <= S_ACK;
                                oe_q    <= 1'b0;
                            end else begin
                                bit_q <= bit_q - 3'd1;
                                oe_q  <= ~cur_byte[bit_q - 3'd1];
                            end
                        end
                        default: ;
                    endcase
                end
                S_ACK: if (tick) begin
                    q_q <= q_q + 2'd1;
                    case (q_q)
                        2'd0: scl_q <= 1'b1;
                        2'd2: begin
                            scl_q  <= 1'b0;
                            nack_q <= I2C_SDAT_IN;
                        end
                        2'd3: begin
                            if (nack_q || (byte_q == 2'd2)) begin
                                state_q <= S_STOP;
                                oe_q    <= 1'b1;
                                fail_q  <= nack_q;
                            end else begin
                                state_q <= S_BIT;
                                byte_q  <= byte_q + 2'd1;
                                bit_q   <= 3'd7;
                                oe_q    <= ~nxt_byte[7];
                            end
                        end
                        default: ;
                    endcase
                end
                S_STOP: if (tick) begin
                    q_q <= q_q + 2'd1;
                    case (q_q)
                        2'd0: scl_q <= 1'b1;
                        2'd1: oe_q  <= 1'b0;
                        2'd2: begin
                            state_q <= S_GAP;
                            q_q     <= 2'd0;
                        end
                        default: ;
                    endcase
                end
                S_GAP: if (tick) begin
                    q_q <= q_q + 2'd1;
                    if (q_q == 2'd3) state_q <= S_NEXT;
                end
                // NEXT lasts one cycle and the divider keeps running into START,
                // so back-to-back writes stay exactly 117 quarters apart
                S_NEXT: begin
                    if (fail_q && (retry_q >= 8'(MAX_RETRIES))) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (!fail_q && (idx_q == 4'd9)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_START;
                        q_q     <= 2'd0;
                        byte_q  <= 2'd0;
                        fail_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        if (fail_q) begin
                            retry_q <= retry_q + 8'd1;
                        end else begin
                            retry_q <= '0;
                            idx_q   <= idx_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign I2C_SCLK    = scl_q;
    assign I2C_SDAT_OE = oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign adc_enable  = done_q;
    assign reg_index   = idx_q;

endmodule

// File: tb/tb_audio_codec_config.sv
// Directed bench for audio_codec_config: a WM8731-like I2C slave model with
// configurable NACKs, a bus protocol monitor, and scenario checks.
module tb_audio_codec_config;

    logic       clk;
    logic       RESET;
    logic       start;
    logic       sda;
    logic       scl;
    logic       oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       adc_enable;
    logic [3:0] reg_index;
    logic       pull;

    int tests = 0;
    int fails = 0;

    // Bus monitor / codec model state
    int          cyc_abs = 0;
    int          txn_cnt = 0;
    int          bitcnt = 0;
    int          bytecnt = 0;
    bit          in_txn = 0;
    int          proto_bad = 0;
    int          stop_bad = 0;
    int          high_bad = 0;
    int          high_start = 0;
    bit          high_valid = 0;
    logic [8:0]  shift = '0;
    logic        scl_p = 1'b1;
    logic        sda_p = 1'b1;
    bit          nack_addr_all = 0;
    bit          nack_once = 0;
    logic [7:0]  log_b [64][3];
    int          log_n [64];

    logic [7:0] exp_b1 [10] = '{8'h1E, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0E, 8'h10, 8'h12};
    logic [7:0] exp_b2 [10] = '{8'h00, 8'h17, 8'h17, 8'h79, 8'h79, 8'h12, 8'h00, 8'h42, 8'h00, 8'h01};

    assign sda = !(oe || pull);

    audio_codec_config #(
        .CLK_DIV(4),
        .DEV_ADDR(7'h1A),
        .MAX_RETRIES(3)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (RESET),
        .start      (start),
        .I2C_SDAT_IN(sda),
        .I2C_SCLK   (scl),
        .I2C_SDAT_OE(oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .adc_enable (adc_enable),
        .reg_index  (reg_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    // Protocol monitor and codec slave, sampled on the falling clock edge
    always @(negedge clk) begin
        logic s_scl;
        logic s_sda;
        bit   nack;
        s_scl = scl;
        s_sda = sda;
        if (RESET) begin
            in_txn     = 0;
            pull       = 1'b0;
            bitcnt     = 0;
            bytecnt    = 0;
            high_valid = 0;
        end else if (scl_p && s_scl && (s_sda != sda_p)) begin
            if (!s_sda) begin
                if (in_txn) proto_bad++;
                in_txn     = 1;
                bitcnt     = 0;
                bytecnt    = 0;
                high_valid = 0;
            end else begin
                if (!in_txn) begin
                    proto_bad++;
                end else begin
                    if (bitcnt != 1) stop_bad++;
                    if (txn_cnt < 64) log_n[txn_cnt] = bytecnt;
                    txn_cnt++;
                end
                in_txn     = 0;
                high_valid = 0;
            end
        end else if (!scl_p && s_scl && in_txn) begin
            shift      = {shift[7:0], s_sda};
            bitcnt++;
            high_start = cyc_abs;
            high_valid = 1;
            if (bitcnt == 9) begin
                if (txn_cnt < 64 && bytecnt < 3) log_b[txn_cnt][bytecnt] = shift[8:1];
                bytecnt++;
                bitcnt = 0;
            end
        end else if (scl_p && !s_scl) begin
            if (high_valid && (cyc_abs - high_start != 8)) high_bad++;
            high_valid = 0;
            if (in_txn && bitcnt == 8) begin
                nack = (nack_addr_all && bytecnt == 0);
                if (nack_once && bytecnt == 2 && txn_cnt < 64 && log_b[txn_cnt][1] == 8'h04) begin
                    nack      = 1;
                    nack_once = 0;
                end
                pull = !nack;
            end else if (bitcnt == 0) begin
                pull = 1'b0;
            end
        end
        scl_p = s_scl;
        sda_p = s_sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_until_end(output int lat);
        lat = 0;
        while (!(done || error) && lat < 6000) begin
            @(negedge clk);
            lat++;
        end
        chk("run_terminated", 32'(done || error), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_full_run(input string tag);
        chk({tag, "_txn_count"}, 32'(txn_cnt), 32'd10);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_adc_enable"}, 32'(adc_enable), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_reg_index"}, 32'(reg_index), 32'd9);
        chk({tag, "_first_b0"}, 32'(log_b[0][0]), 32'h34);
        chk({tag, "_first_b1"}, 32'(log_b[0][1]), 32'h1E);
        chk({tag, "_first_b2"}, 32'(log_b[0][2]), 32'h00);
        chk({tag, "_last_b1"}, 32'(log_b[9][1]), 32'h12);
        chk({tag, "_last_b2"}, 32'(log_b[9][2]), 32'h01);
    endtask

    initial begin
        int lat;
        int guard;
        RESET = 1'b1;
        start = 1'b0;
        pull  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_adc_enable", 32'(adc_enable), 32'd0);
        chk("rst_reg_index", 32'(reg_index), 32'd0);

        // Scenario 1: auto-run, everything ACKed
        txn_cnt = 0;
        RESET   = 1'b0;
        @(negedge clk);
        chk("s1_autorun_busy", 32'(busy), 32'd1);
        run_until_end(lat);
        chk("s1_done_latency", 32'(lat >= 4678 && lat <= 4682), 32'd1);
        check_full_run("s1");
        for (int i = 0; i < 10; i++) begin
            chk("s1_tbl_b0", 32'(log_b[i][0]), 32'h34);
            chk("s1_tbl_b1", 32'(log_b[i][1]), 32'(exp_b1[i]));
            chk("s1_tbl_b2", 32'(log_b[i][2]), 32'(exp_b2[i]));
        end
        chk("s1_scl_high_8_cycles", 32'(high_bad), 32'd0);

        // Scenario 5: start after done reruns; start while busy is ignored
        txn_cnt = 0;
        pulse_start();
        chk("s5_restart_done", 32'(done), 32'd0);
        chk("s5_restart_adc", 32'(adc_enable), 32'd0);
        chk("s5_restart_busy", 32'(busy), 32'd1);
        chk("s5_restart_idx", 32'(reg_index), 32'd0);
        repeat (1000) @(negedge clk);
        pulse_start();
        chk("s5_busy_after_ignored_start", 32'(busy), 32'd1);
        run_until_end(lat);
        lat = lat + 1001;
        chk("s5_done_latency", 32'(lat >= 4678 && lat <= 4682), 32'd1);
        check_full_run("s5");

        // Scenario 2: single NACK on the data byte of entry 3
        txn_cnt   = 0;
        nack_once = 1;
        pulse_start();
        run_until_end(lat);
        chk("s2_txn_count", 32'(txn_cnt), 32'd11);
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_error", 32'(error), 32'd0);
        chk("s2_nacked_len", 32'(log_n[3]), 32'd3);
        chk("s2_retry_b1", 32'(log_b[4][1]), 32'h04);
        chk("s2_retry_b2", 32'(log_b[4][2]), 32'h79);
        chk("s2_after_retry_b1", 32'(log_b[5][1]), 32'h06);

        // Scenario 3: address always NACKed -> error after 4 attempts
        txn_cnt       = 0;
        nack_addr_all = 1;
        pulse_start();
        run_until_end(lat);
        chk("s3_error", 32'(error), 32'd1);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_adc_enable", 32'(adc_enable), 32'd0);
        chk("s3_done", 32'(done), 32'd0);
        chk("s3_reg_index", 32'(reg_index), 32'd0);
        chk("s3_attempts", 32'(txn_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("s3_attempt_len", 32'(log_n[i]), 32'd1);
        nack_addr_all = 0;
        txn_cnt       = 0;
        pulse_start();
        chk("s3_restart_error", 32'(error), 32'd0);
        chk("s3_restart_busy", 32'(busy), 32'd1);
        run_until_end(lat);
        check_full_run("s3");

        // Scenario 4: reset inside entry 5
        txn_cnt = 0;
        pulse_start();
        guard = 0;
        while (!(txn_cnt == 5 && in_txn && bytecnt == 1) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        chk("s4_reached_entry5", 32'(txn_cnt == 5 && bytecnt == 1), 32'd1);
        chk("s4_idx_before_reset", 32'(reg_index), 32'd5);
        repeat (10) @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        chk("s4_rst_scl", 32'(scl), 32'd1);
        chk("s4_rst_oe", 32'(oe), 32'd0);
        chk("s4_rst_busy", 32'(busy), 32'd0);
        chk("s4_rst_idx", 32'(reg_index), 32'd0);
        @(negedge clk);
        txn_cnt = 0;
        RESET   = 1'b0;
        @(negedge clk);
        chk("s4_release_busy", 32'(busy), 32'd1);
        run_until_end(lat);
        chk("s4_done_latency", 32'(lat >= 4678 && lat <= 4682), 32'd1);
        check_full_run("s4");

        // Scenario 6: protocol monitor over the whole run
        chk("s6_sda_stable_while_scl_high", 32'(proto_bad), 32'd0);
        chk("s6_nine_scl_pulses_per_byte", 32'(stop_bad), 32'd0);
        chk("s6_scl_high_8_cycles", 32'(high_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
